// File: rtl/pht_table_if.sv
// rtl/pht_table_if.sv - Lookup/update/clear bundle for the pattern history table.
//
// Purpose: carries the predict, update and clear/busy signals between the
//          fetch/resolution logic (master) and pht_table (slave).
// Signals: pred_valid_i, pred_index_i      lookup request
//          pred_valid_o, pred_taken_o,
//          pred_ctr_o                      registered lookup result
//          upd_valid_i, upd_index_i,
//          upd_taken_i                     resolved-branch update
//          clear_i, busy_o                 clear sweep control/status
//          upd_pred_i, stat_upd_o,
//          stat_miss_o                     only with PHT_STATS_EN defined
interface pht_table_if #(
  parameter int INDEX_W = 4,
  parameter int CTR_W   = 2
);
  logic               pred_valid_i;
  logic [INDEX_W-1:0] pred_index_i;
  logic               pred_valid_o;
  logic               pred_taken_o;
  logic [CTR_W-1:0]   pred_ctr_o;
  logic               upd_valid_i;
  logic [INDEX_W-1:0] upd_index_i;
  logic               upd_taken_i;
  logic               clear_i;
  logic               busy_o;
`ifdef PHT_STATS_EN
  logic               upd_pred_i;
  logic [15:0]        stat_upd_o;
  logic [15:0]        stat_miss_o;
`endif

  modport master (
    output pred_valid_i, pred_index_i,
    input  pred_valid_o, pred_taken_o, pred_ctr_o,
    output upd_valid_i, upd_index_i, upd_taken_i,
    output clear_i,
`ifdef PHT_STATS_EN
    output upd_pred_i,
    input  stat_upd_o, stat_miss_o,
`endif
    input  busy_o
  );

  modport slave (
    input  pred_valid_i, pred_index_i,
    output pred_valid_o, pred_taken_o, pred_ctr_o,
    input  upd_valid_i, upd_index_i, upd_taken_i,
    input  clear_i,
`ifdef PHT_STATS_EN
    input  upd_pred_i,
    output stat_upd_o, stat_miss_o,
`endif
    output busy_o
  );
endinterface

// File: rtl/pht_table.sv
// rtl/pht_table.sv - Parametrised pattern history table with clear sweep.
//
// Purpose: DEPTH = 2**INDEX_W saturating CTR_W-bit counters. Registered lookup
//          with same-cycle update bypass, saturating update, and a clear
//          sweep FSM (IDLE/CLEAR) that rewrites one entry per cycle to INIT_VAL.
// Ports:   clk    rising-edge clock
//          reset  asynchronous active-high reset
//          bus    pht_table_if.slave (lookup, update, clear_i, busy_o)
// Option:  PHT_STATS_EN adds upd_pred_i and the stat_upd_o/stat_miss_o
//          saturating 16-bit update/mispredict counters.
module pht_table #(
  parameter int INDEX_W  = 4,
  parameter int CTR_W    = 2,
  parameter int INIT_VAL = 0
) (
  input  logic        clk,
  input  logic        reset,
  pht_table_if.slave  bus
);
  localparam int DEPTH = 2 ** INDEX_W;
  localparam logic [CTR_W-1:0] INIT_CTR    = CTR_W'(INIT_VAL);
  localparam logic [CTR_W-1:0] CTR_MAX     = {CTR_W{1'b1}};
  localparam logic [CTR_W:0]   CTR_MAX_EXT = {1'b0, CTR_MAX};
  localparam logic [INDEX_W-1:0] LAST_IDX  = INDEX_W'(DEPTH - 1);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [INDEX_W-1:0] ptr_q, ptr_d;
  logic [CTR_W-1:0]   table_q [DEPTH];
  logic [CTR_W-1:0]   table_d [DEPTH];
  logic               pred_valid_q, pred_valid_d;
  logic               pred_taken_q, pred_taken_d;
  logic [CTR_W-1:0]   pred_ctr_q, pred_ctr_d;
  logic               busy_q, busy_d;

  logic               idle;
  logic               upd_acc;
  logic [CTR_W-1:0]   upd_cur;
  logic [CTR_W:0]     upd_inc;
  logic [CTR_W:0]     upd_dec;
  logic [CTR_W-1:0]   upd_new;
  logic [CTR_W-1:0]   look_ctr;

  assign idle    = (state_q == IDLE);
  assign upd_acc = idle && bus.upd_valid_i;

  // Arithmetic one bit wider than the counter so saturation is detected
  // before any wrap: overflow shows as > max, underflow sets the extra MSB.
  always_comb begin
    upd_cur = table_q[bus.upd_index_i];
    upd_inc = {1'b0, upd_cur} + 1'b1;
    upd_dec = {1'b0, upd_cur} - 1'b1;
    upd_new = upd_cur;
    if (bus.upd_taken_i) begin
      upd_new = (upd_inc > CTR_MAX_EXT) ? CTR_MAX : upd_inc[CTR_W-1:0];
    end else begin
      upd_new = upd_dec[CTR_W] ? '0 : upd_dec[CTR_W-1:0];
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    table_d      = table_q;
    pred_valid_d = 1'b0;
    pred_taken_d = pred_taken_q;
    pred_ctr_d   = pred_ctr_q;
    look_ctr     = table_q[bus.pred_index_i];

    // Bypass: a lookup racing an update of the same entry sees the new value.
    if (upd_acc && (bus.upd_index_i == bus.pred_index_i)) begin
      look_ctr = upd_new;
    end

    case (state_q)
      IDLE: begin
        if (bus.upd_valid_i) begin
          table_d[bus.upd_index_i] = upd_new;
        end
        if (bus.pred_valid_i) begin
          pred_valid_d = 1'b1;
          pred_ctr_d   = look_ctr;
          pred_taken_d = look_ctr[CTR_W-1];
        end
        if (bus.clear_i) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        table_d[ptr_q] = INIT_CTR;
        ptr_d          = ptr_q + 1'b1;
        if (ptr_q == LAST_IDX) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == CLEAR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_ctr_q   <= '0;
      busy_q       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= INIT_CTR;
      end
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      pred_valid_q <= pred_valid_d;
      pred_taken_q <= pred_taken_d;
      pred_ctr_q   <= pred_ctr_d;
      busy_q       <= busy_d;
      table_q      <= table_d;
    end
  end

  assign bus.pred_valid_o = pred_valid_q;
  assign bus.pred_taken_o = pred_taken_q;
  assign bus.pred_ctr_o   = pred_ctr_q;
  assign bus.busy_o       = busy_q;

`ifdef PHT_STATS_EN
  logic [15:0] stat_upd_q, stat_upd_d;
  logic [15:0] stat_miss_q, stat_miss_d;

  // An accepted clear wins over an update in the same cycle.
  always_comb begin
    stat_upd_d  = stat_upd_q;
    stat_miss_d = stat_miss_q;
    if (idle && bus.clear_i) begin
      stat_upd_d  = '0;
      stat_miss_d = '0;
    end else if (upd_acc) begin
      if (stat_upd_q != 16'hFFFF) begin
        stat_upd_d = stat_upd_q + 16'd1;
      end
      if ((bus.upd_pred_i != bus.upd_taken_i) && (stat_miss_q != 16'hFFFF)) begin
        stat_miss_d = stat_miss_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_upd_q  <= '0;
      stat_miss_q <= '0;
    end else begin
      stat_upd_q  <= stat_upd_d;
      stat_miss_q <= stat_miss_d;
    end
  end

  assign bus.stat_upd_o  = stat_upd_q;
  assign bus.stat_miss_o = stat_miss_q;
`endif
endmodule

// File: tb/tb_pht_table.sv
// tb/tb_pht_table.sv - Directed self-checking bench for pht_table.
module tb_pht_table;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  pht_table_if #(.INDEX_W(4), .CTR_W(2)) bus ();

  pht_table #(.INDEX_W(4), .CTR_W(2), .INIT_VAL(0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.pred_valid_i = 1'b0;
    bus.pred_index_i = '0;
    bus.upd_valid_i  = 1'b0;
    bus.upd_index_i  = '0;
    bus.upd_taken_i  = 1'b0;
    bus.clear_i      = 1'b0;
`ifdef PHT_STATS_EN
    bus.upd_pred_i   = 1'b0;
`endif
  endtask

  task automatic do_update(input logic [3:0] idx, input logic taken);
    bus.upd_valid_i = 1'b1;
    bus.upd_index_i = idx;
    bus.upd_taken_i = taken;
    step();
    bus.upd_valid_i = 1'b0;
  endtask

  task automatic lookup(input logic [3:0] idx, output logic vld, output logic [1:0] ctr,
                        output logic tkn);
    bus.pred_valid_i = 1'b1;
    bus.pred_index_i = idx;
    step();
    bus.pred_valid_i = 1'b0;
    vld = bus.pred_valid_o;
    ctr = bus.pred_ctr_o;
    tkn = bus.pred_taken_o;
  endtask

  task automatic wait_not_busy(input string tag);
    int n = 0;
    while (bus.busy_o && n < 40) begin
      n++;
      step();
    end
    check_eq(tag, 32'(bus.busy_o), 32'd0);
  endtask

  initial begin
    logic       vld;
    logic       tkn;
    logic [1:0] ctr;
    logic       drop_bad;
    int         busy_cnt;

    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_pred_valid", 32'(bus.pred_valid_o), 32'd0);
    check_eq("rst_pred_ctr",   32'(bus.pred_ctr_o),   32'd0);
    check_eq("rst_pred_taken", 32'(bus.pred_taken_o), 32'd0);
    check_eq("rst_busy",       32'(bus.busy_o),       32'd0);
    reset = 1'b0;
    step();

    // 1: lookup after reset, then result holds with no request
    lookup(4'd5, vld, ctr, tkn);
    check_eq("t1_valid", 32'(vld), 32'd1);
    check_eq("t1_ctr",   32'(ctr), 32'd0);
    check_eq("t1_taken", 32'(tkn), 32'd0);
    step();
    check_eq("t1_valid_drop", 32'(bus.pred_valid_o), 32'd0);

    // 2: saturation both ways
    repeat (4) do_update(4'd3, 1'b1);
    lookup(4'd3, vld, ctr, tkn);
    check_eq("t2_sat_hi_ctr",   32'(ctr), 32'd3);
    check_eq("t2_sat_hi_taken", 32'(tkn), 32'd1);
    step();
    check_eq("t2_hold_ctr", 32'(bus.pred_ctr_o), 32'd3);
    repeat (4) do_update(4'd3, 1'b0);
    lookup(4'd3, vld, ctr, tkn);
    check_eq("t2_sat_lo_ctr",   32'(ctr), 32'd0);
    check_eq("t2_sat_lo_taken", 32'(tkn), 32'd0);

    // 3: same-cycle bypass
    do_update(4'd7, 1'b1);
    bus.upd_valid_i  = 1'b1;
    bus.upd_index_i  = 4'd7;
    bus.upd_taken_i  = 1'b1;
    lookup(4'd7, vld, ctr, tkn);
    bus.upd_valid_i  = 1'b0;
    check_eq("t3_bypass_valid", 32'(vld), 32'd1);
    check_eq("t3_bypass_ctr",   32'(ctr), 32'd2);
    check_eq("t3_bypass_taken", 32'(tkn), 32'd1);
    bus.upd_valid_i  = 1'b1;
    bus.upd_index_i  = 4'd7;
    bus.upd_taken_i  = 1'b0;
    lookup(4'd8, vld, ctr, tkn);
    bus.upd_valid_i  = 1'b0;
    check_eq("t3_other_idx_ctr", 32'(ctr), 32'd0);
    lookup(4'd7, vld, ctr, tkn);
    check_eq("t3_written_back", 32'(ctr), 32'd1);

    // 4: train all to 2 (entry 7 currently 1), then sweep
    do_update(4'd7, 1'b0);
    for (int i = 0; i < 16; i++) begin
      do_update(4'(i), 1'b1);
      do_update(4'(i), 1'b1);
    end
    lookup(4'd9, vld, ctr, tkn);
    check_eq("t4_trained_9", 32'(ctr), 32'd2);
    lookup(4'd7, vld, ctr, tkn);
    check_eq("t4_trained_7", 32'(ctr), 32'd2);
    bus.clear_i = 1'b1;
    step();
    bus.clear_i = 1'b0;
    bus.pred_valid_i = 1'b1;
    bus.pred_index_i = 4'd15;
    bus.upd_valid_i  = 1'b1;
    bus.upd_index_i  = 4'd15;
    bus.upd_taken_i  = 1'b1;
    busy_cnt = 0;
    drop_bad = 1'b0;
    while (bus.busy_o && busy_cnt < 40) begin
      busy_cnt++;
      if (bus.pred_valid_o) drop_bad = 1'b1;
      step();
    end
    idle_inputs();
    check_eq("t4_busy_cycles", 32'(busy_cnt), 32'd16);
    check_eq("t4_dropped",     32'(drop_bad), 32'd0);
    for (int i = 0; i < 16; i++) begin
      lookup(4'(i), vld, ctr, tkn);
      check_eq($sformatf("t4_cleared_%0d", i), 32'(ctr), 32'd0);
    end

    // 5: reset mid-sweep at ptr=6
    repeat (3) do_update(4'd10, 1'b1);
    repeat (2) do_update(4'd2, 1'b1);
    bus.clear_i = 1'b1;
    step();
    bus.clear_i = 1'b0;
    repeat (6) step();
    check_eq("t5_busy_before", 32'(bus.busy_o), 32'd1);
    reset = 1'b1;
    #2;
    check_eq("t5_busy_async", 32'(bus.busy_o), 32'd0);
    step();
    reset = 1'b0;
    lookup(4'd10, vld, ctr, tkn);
    check_eq("t5_entry10", 32'(ctr), 32'd0);
    lookup(4'd2, vld, ctr, tkn);
    check_eq("t5_entry2", 32'(ctr), 32'd0);
    bus.clear_i = 1'b1;
    step();
    bus.clear_i = 1'b0;
    check_eq("t5_reclear_busy", 32'(bus.busy_o), 32'd1);
    wait_not_busy("t5_sweep_done");

`ifdef PHT_STATS_EN
    // 6: 10 updates, first 3 mispredicted
    for (int i = 0; i < 10; i++) begin
      bus.upd_pred_i = (i < 3) ? ~1'(i) : 1'(i);
      do_update(4'd4, 1'(i));
    end
    check_eq("t6_stat_upd",  32'(bus.stat_upd_o),  32'd10);
    check_eq("t6_stat_miss", 32'(bus.stat_miss_o), 32'd3);
    bus.clear_i = 1'b1;
    step();
    bus.clear_i = 1'b0;
    check_eq("t6_clr_upd",  32'(bus.stat_upd_o),  32'd0);
    check_eq("t6_clr_miss", 32'(bus.stat_miss_o), 32'd0);
    wait_not_busy("t6_sweep_done");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pht_table.md
Name: pht_table

Overview:
Parametrised pattern history table: the generalised successor of the 16-entry 2-bit BHT used by the global predictor.
- Configurable depth, counter width and counter reset value.
- Separate predict (lookup) and update ports; registered prediction with same-cycle update bypass.
- Software-triggered clear sweep FSM.
- Sits between the global-history index generator and the fetch-stage predict logic; the update port is driven from branch resolution.

Parameters:
INDEX_W, 4, index width; table depth DEPTH = 2**INDEX_W entries.
CTR_W, 2, saturating counter width (legal 1..4).
INIT_VAL, 0, counter value loaded on reset and by the clear sweep (must be < 2**CTR_W).

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
pred_valid_i  in  1  lookup request this cycle.
pred_index_i  in  INDEX_W  lookup index.
pred_valid_o  out  1  lookup result valid (one cycle after the request).
pred_taken_o  out  1  predicted direction = MSB of counter.
pred_ctr_o  out  CTR_W  counter value returned by the lookup.
upd_valid_i  in  1  resolved-branch update this cycle.
upd_index_i  in  INDEX_W  update index.
upd_taken_i  in  1  actual outcome (1 = taken).
clear_i  in  1  start clear sweep (single-cycle pulse, sampled in IDLE only).
busy_o  out  1  high while the clear sweep runs.

Behaviour:
Reset:
- reset asynchronously sets all DEPTH entries to INIT_VAL and the FSM to IDLE.
- Output reset values: pred_valid_o=0, pred_taken_o=0, pred_ctr_o=0, busy_o=0, sweep pointer=0.

Update (IDLE only):
- When upd_valid_i=1, entry[upd_index_i] is written at the rising edge.
- Taken: counter+1, saturating at 2**CTR_W-1.
- Not taken: counter-1, saturating at 0.
- Back-to-back updates to the same index each see the previous write, because the write completes at the edge.

Lookup (IDLE only):
- pred_valid_i=1 registers the result; pred_valid_o=1 one cycle later, together with pred_ctr_o and pred_taken_o.
- Bypass: if upd_valid_i=1 with upd_index_i==pred_index_i in the same cycle, the registered result is the post-update counter value.
- With no request, pred_valid_o=0 and pred_taken_o/pred_ctr_o hold their last values.

FSM states IDLE and CLEAR:
- IDLE -> CLEAR when clear_i=1; the sweep pointer loads 0.
- In CLEAR, one entry per cycle is set to INIT_VAL: entry[ptr] <= INIT_VAL, ptr increments.
- CLEAR -> IDLE after writing ptr==DEPTH-1, i.e. exactly DEPTH cycles in CLEAR; busy_o=1 for those DEPTH cycles.
- busy_o is a registered state decode; it rises the cycle after clear_i is sampled.

During CLEAR:
- Lookup and update requests are dropped.
- pred_valid_o=0 and the table is unchanged except by the sweep.
- clear_i is ignored.

Reset mid-sweep: immediate return to IDLE with all entries at INIT_VAL.

Widths: counter arithmetic is done at CTR_W+1 bits before saturation, so no wrap-around is possible.

Optional Feature:
Macro name: PHT_STATS_EN.

When defined:
- Adds input upd_pred_i (1 bit: direction that was predicted for this update).
- Adds outputs stat_upd_o (16 bits) and stat_miss_o (16 bits).
- stat_upd_o increments on every accepted update.
- stat_miss_o increments on every accepted update where upd_pred_i != upd_taken_i.
- Both counters saturate at 16'hFFFF.
- Both counters are cleared by reset and on the cycle clear_i is accepted.

When undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
1. Reset -> lookup index 5 returns pred_valid_o=1, pred_ctr_o=0, pred_taken_o=0 one cycle later (default parameters).
2. Four taken updates to index 3, then lookup 3 -> pred_ctr_o=3 (saturated), pred_taken_o=1; four not-taken updates -> pred_ctr_o=0, no wrap to 3.
3. Same cycle: update index 7 taken (entry=1) plus lookup index 7 -> next cycle pred_ctr_o=2, pred_taken_o=1 (bypass); lookup index 8 in the same cycle is unaffected.
4. Train entries 0..15 to 2, pulse clear_i -> busy_o high 16 cycles, lookups and updates dropped (pred_valid_o=0), then all entries read 0.
5. Assert reset during the sweep at ptr=6 -> busy_o=0 immediately, all entries read INIT_VAL, a new clear_i is accepted.
6. PHT_STATS_EN: 10 updates with 3 where upd_pred_i != upd_taken_i -> stat_upd_o=10, stat_miss_o=3; clear_i -> both 0.
